// File: rtl/hazard_unit_param.sv
// Hazard unit: operand forwarding over external + retire-history sources, multi-cycle load-use
// interlock FSM, and stall/flush merge per pipeline boundary. Optional CSR forwarding: HAZARD_CSR_FWD_EN.
module hazard_unit_param_match #(
    parameter int AW = 5,
    parameter bit NZ = 1'b1
) (
    input  logic          i_we,
    input  logic [AW-1:0] i_dst,
    input  logic [AW-1:0] i_src,
    output logic          o_hit
);
    // NZ excludes the hard-wired zero register from matching
    assign o_hit = i_we && (i_dst == i_src) && (!NZ || (i_dst != '0));
endmodule

module hazard_unit_param #(
    parameter int FWD_SRCS        = 2,
    parameter int RET_DEPTH       = 1,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int NB              = 4,
    parameter int SELW            = $clog2(FWD_SRCS + RET_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_enable,
    input  logic                    trap_done,
    input  logic                    csr_ready,
    input  logic                    standby_mode,
    input  logic                    pth_done_flush,
    input  logic                    branch_prediction_miss,
    input  logic                    EX_jump,
    input  logic [4:0]              ID_rs1,
    input  logic [4:0]              ID_rs2,
    input  logic                    ID_rs1_used,
    input  logic                    ID_rs2_used,
    input  logic [4:0]              EX_rs1,
    input  logic [4:0]              EX_rs2,
    input  logic [4:0]              EX_rd,
    input  logic                    EX_is_load,
    input  logic [5*FWD_SRCS-1:0]   src_rd,
    input  logic [FWD_SRCS-1:0]     src_we,
`ifdef HAZARD_CSR_FWD_EN
    input  logic [FWD_SRCS-1:0]     src_csr_we,
    input  logic [12*FWD_SRCS-1:0]  src_csr_addr,
    input  logic [11:0]             EX_csr_addr,
    output logic [SELW-1:0]         csr_fwd_sel,
`endif
    output logic [SELW-1:0]         fwd_sel_rs1,
    output logic [SELW-1:0]         fwd_sel_rs2,
    output logic [NB-1:0]           stall,
    output logic [NB-1:0]           flush,
    output logic                    load_stall_active
);
    localparam int NSRC = FWD_SRCS + RET_DEPTH;
    localparam int CW   = 4;

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [NSRC-1:0][4:0] w_rd;
    logic [NSRC-1:0]      w_we, w_hit1, w_hit2;
    logic                 w_detect, w_redir, w_hold, w_lu;
    logic [NB-1:0]        w_stall, w_flush;

    function automatic logic [SELW-1:0] f_prio(input logic [NSRC-1:0] hit);
        f_prio = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (hit[i]) f_prio = SELW'(i + 1);
    endfunction

    assign w_rd[FWD_SRCS-1:0] = src_rd;
    assign w_we[FWD_SRCS-1:0] = src_we;

    generate
        if (RET_DEPTH > 0) begin : g_ret
            logic [RET_DEPTH-1:0][4:0] r_ret_rd;
            logic [RET_DEPTH-1:0]      r_ret_we;
            // Retire history tracks what the oldest external stage hands to the register file
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_ret_rd <= '0;
                    r_ret_we <= '0;
                end else if (clk_enable && !w_stall[NB-1]) begin
                    r_ret_rd[0] <= src_rd[5*FWD_SRCS-1 -: 5];
                    r_ret_we[0] <= src_we[FWD_SRCS-1];
                    for (int i = 1; i < RET_DEPTH; i++) begin
                        r_ret_rd[i] <= r_ret_rd[i-1];
                        r_ret_we[i] <= r_ret_we[i-1];
                    end
                end
            end
            assign w_rd[NSRC-1:FWD_SRCS] = r_ret_rd;
            assign w_we[NSRC-1:FWD_SRCS] = r_ret_we;
        end

        for (genvar g = 0; g < NSRC; g++) begin : g_src
            hazard_unit_param_match #(.AW(5), .NZ(1'b1)) u_m1 (
                .i_we(w_we[g]), .i_dst(w_rd[g]), .i_src(EX_rs1), .o_hit(w_hit1[g]));
            hazard_unit_param_match #(.AW(5), .NZ(1'b1)) u_m2 (
                .i_we(w_we[g]), .i_dst(w_rd[g]), .i_src(EX_rs2), .o_hit(w_hit2[g]));
        end
    endgenerate

`ifdef HAZARD_CSR_FWD_EN
    logic [FWD_SRCS-1:0] w_chit;
    generate
        for (genvar g = 0; g < FWD_SRCS; g++) begin : g_csr
            hazard_unit_param_match #(.AW(12), .NZ(1'b0)) u_mc (
                .i_we(src_csr_we[g]), .i_dst(src_csr_addr[12*g +: 12]),
                .i_src(EX_csr_addr), .o_hit(w_chit[g]));
        end
    endgenerate
    assign csr_fwd_sel = reset_n ? f_prio(NSRC'(w_chit)) : '0;
`endif

    assign fwd_sel_rs1 = reset_n ? f_prio(w_hit1) : '0;
    assign fwd_sel_rs2 = reset_n ? f_prio(w_hit2) : '0;

    assign w_detect = EX_is_load && (EX_rd != 5'd0) &&
                      ((ID_rs1_used && EX_rd == ID_rs1) || (ID_rs2_used && EX_rd == ID_rs2));
    assign w_redir  = trap_done && (branch_prediction_miss || EX_jump);
    assign w_hold   = standby_mode || !trap_done || !csr_ready;
    // Redirects and full flushes squash the interlock pattern outright
    assign w_lu     = ((r_state == LU_STALL) || w_detect) && !w_redir && !pth_done_flush;

    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (w_lu) begin
            w_stall[1:0] = 2'b11;
            w_flush[2]   = 1'b1;
        end
        if (w_redir)        w_flush[1:0] = 2'b11;
        if (pth_done_flush) w_flush      = '1;
        if (standby_mode) begin
            w_stall      = '0;
            w_stall[1:0] = 2'b11;
        end else if (!trap_done || !csr_ready) begin
            w_stall = '1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (pth_done_flush || w_redir) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else if (!w_hold) begin
            if (r_state == RUN) begin
                if (w_detect && LOAD_USE_CYCLES > 1) begin
                    w_state_nxt = LU_STALL;
                    w_cnt_nxt   = CW'(LOAD_USE_CYCLES - 1);
                end
            end else if (r_cnt <= CW'(1)) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else if (clk_enable) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign stall             = reset_n ? w_stall : '0;
    assign flush             = reset_n ? w_flush : '0;
    assign load_stall_active = (r_state == LU_STALL);
endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed + randomized bench for hazard_unit_param against a cycle-level behavioural model.
module tb_hazard_unit_param;
    localparam int FS = 2;
    localparam int RDP = 1;
    localparam int L = 3;

    logic clk = 1'b0;
    logic reset_n, clk_enable, trap_done, csr_ready, standby_mode, pth_done_flush;
    logic branch_prediction_miss, EX_jump;
    logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd;
    logic ID_rs1_used, ID_rs2_used, EX_is_load;
    logic [5*FS-1:0] src_rd;
    logic [FS-1:0] src_we;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [3:0] stall, flush;
    logic load_stall_active;

    int checks = 0;
    int failures = 0;
    int m_rem;
    logic [4:0] m_hrd [RDP];
    logic m_hwe [RDP];
    logic [3:0] last_stall, last_flush;
    logic last_lsa;

    always #5 clk = ~clk;

    hazard_unit_param #(.FWD_SRCS(FS), .RET_DEPTH(RDP), .LOAD_USE_CYCLES(L), .NB(4)) dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .trap_done(trap_done),
        .csr_ready(csr_ready), .standby_mode(standby_mode), .pth_done_flush(pth_done_flush),
        .branch_prediction_miss(branch_prediction_miss), .EX_jump(EX_jump),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_is_load(EX_is_load),
        .src_rd(src_rd), .src_we(src_we), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .stall(stall), .flush(flush), .load_stall_active(load_stall_active));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First matching source in youngest-first order; 0 means register file
    function automatic int ref_sel(input logic [4:0] rs);
        for (int k = 0; k < FS; k++)
            if (src_we[k] && src_rd[5*k +: 5] != 5'd0 && src_rd[5*k +: 5] == rs) return k + 1;
        for (int k = 0; k < RDP; k++)
            if (m_hwe[k] && m_hrd[k] != 5'd0 && m_hrd[k] == rs) return FS + k + 1;
        return 0;
    endfunction

    task automatic idle_inputs();
        clk_enable = 1; trap_done = 1; csr_ready = 1; standby_mode = 0; pth_done_flush = 0;
        branch_prediction_miss = 0; EX_jump = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rs1_used = 0;
        ID_rs2_used = 0; EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0; EX_is_load = 0; src_rd = '0; src_we = '0;
    endtask

    task automatic model_reset();
        m_rem = 0;
        for (int k = 0; k < RDP; k++) begin m_hrd[k] = 5'd0; m_hwe[k] = 1'b0; end
    endtask

    task automatic cycle();
        logic det, redir, hold_all;
        logic [3:0] es, ef;
        @(negedge clk);
        det = EX_is_load && EX_rd != 0 &&
              ((ID_rs1_used && EX_rd == ID_rs1) || (ID_rs2_used && EX_rd == ID_rs2));
        redir = trap_done && (branch_prediction_miss || EX_jump);
        hold_all = !trap_done || !csr_ready;
        es = 4'b0000; ef = 4'b0000;
        if (pth_done_flush) ef = 4'b1111;
        else if (redir) ef = 4'b0011;
        else if (m_rem > 0 || det) begin ef = 4'b0100; es = 4'b0011; end
        if (standby_mode) es = 4'b0011;
        else if (hold_all) es = 4'b1111;
        chk("sel_rs1", 8'(fwd_sel_rs1), 8'(ref_sel(EX_rs1)));
        chk("sel_rs2", 8'(fwd_sel_rs2), 8'(ref_sel(EX_rs2)));
        chk("stall", 8'(stall), 8'(es));
        chk("flush", 8'(flush), 8'(ef));
        chk("lsa", 8'(load_stall_active), 8'(m_rem > 0));
        last_stall = stall; last_flush = flush; last_lsa = load_stall_active;
        @(posedge clk);
        if (clk_enable) begin
            if (pth_done_flush || redir) m_rem = 0;
            else if (!(standby_mode || hold_all)) begin
                if (m_rem > 0) m_rem--;
                else if (det) m_rem = L - 1;
            end
            if (!es[3]) begin
                for (int k = RDP - 1; k > 0; k--) begin m_hrd[k] = m_hrd[k-1]; m_hwe[k] = m_hwe[k-1]; end
                m_hrd[0] = src_rd[5*FS-1 -: 5];
                m_hwe[0] = src_we[FS-1];
            end
        end
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sel1"}, 8'(fwd_sel_rs1), 8'd0);
        chk({tag, "_sel2"}, 8'(fwd_sel_rs2), 8'd0);
        chk({tag, "_stall"}, 8'(stall), 8'd0);
        chk({tag, "_flush"}, 8'(flush), 8'd0);
        chk({tag, "_lsa"}, 8'(load_stall_active), 8'd0);
    endtask

    task automatic set_load_hazard(input logic used);
        EX_is_load = 1; EX_rd = 5'd3; ID_rs1 = 5'd3; ID_rs1_used = used;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 0;
        // Hazard-provoking inputs during reset must not leak to outputs
        set_load_hazard(1'b1);
        src_rd = {5'd5, 5'd5}; src_we = 2'b11; EX_rs1 = 5'd5; pth_done_flush = 1;
        #12;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        idle_inputs();
        reset_n = 1;

        src_rd = {5'd5, 5'd5}; src_we = 2'b11; EX_rs1 = 5'd5;
        #1 chk("fwd_mem_wins", 8'(fwd_sel_rs1), 8'd1);
        cycle();
        src_we = 2'b10;
        #1 chk("fwd_wb_only", 8'(fwd_sel_rs1), 8'd2);
        cycle();

        src_rd = {5'd7, 5'd0}; src_we = 2'b10; EX_rs1 = 0; EX_rs2 = 5'd7;
        cycle();
        src_rd = '0; src_we = '0;
        #1 chk("fwd_retire", 8'(fwd_sel_rs2), 8'(FS + 1));
        EX_rs2 = 5'd0;
        #1 chk("fwd_x0", 8'(fwd_sel_rs2), 8'd0);
        cycle();

        set_load_hazard(1'b1);
        cycle();
        chk("lu_c0_stall", 8'(last_stall), 8'h3);
        chk("lu_c0_flush", 8'(last_flush), 8'h4);
        EX_is_load = 0;
        cycle();
        chk("lu_c1_stall", 8'(last_stall), 8'h3);
        cycle();
        chk("lu_c2_stall", 8'(last_stall), 8'h3);
        chk("lu_c2_flush", 8'(last_flush), 8'h4);
        cycle();
        chk("lu_release", 8'(last_stall), 8'h0);
        chk("lu_release_lsa", 8'(last_lsa), 8'h0);

        set_load_hazard(1'b0);
        cycle();
        chk("lu_unused", 8'(last_stall), 8'h0);
        idle_inputs();

        set_load_hazard(1'b1);
        cycle();
        EX_is_load = 0; pth_done_flush = 1;
        cycle();
        chk("pth_flush", 8'(last_flush), 8'hF);
        chk("pth_lsa_before", 8'(last_lsa), 8'h1);
        pth_done_flush = 0;
        cycle();
        chk("pth_lsa_after", 8'(last_lsa), 8'h0);
        chk("pth_no_stall", 8'(last_stall), 8'h0);

        set_load_hazard(1'b1); branch_prediction_miss = 1;
        cycle();
        chk("redir_flush", 8'(last_flush), 8'h3);
        chk("redir_stall", 8'(last_stall), 8'h0);
        idle_inputs();
        cycle();
        chk("redir_no_lu", 8'(last_lsa), 8'h0);

        set_load_hazard(1'b1);
        cycle();
        idle_inputs(); csr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("csr_hold_stall", 8'(last_stall), 8'hF);
            chk("csr_hold_lsa", 8'(last_lsa), 8'h1);
        end
        csr_ready = 1;
        cycle();
        chk("csr_resume1", 8'(last_stall), 8'h3);
        cycle();
        chk("csr_resume2", 8'(last_stall), 8'h3);
        cycle();
        chk("csr_done", 8'(last_stall), 8'h0);

        set_load_hazard(1'b1);
        cycle();
        idle_inputs();
        cycle();
        set_load_hazard(1'b1);
        reset_n = 0;
        #1 chk_zero_outputs("midreset");
        model_reset();
        #2 reset_n = 1;
        idle_inputs();
        cycle();
        chk("post_reset_stall", 8'(last_stall), 8'h0);
        chk("post_reset_lsa", 8'(last_lsa), 8'h0);

        for (int n = 0; n < 1500; n++) begin
            clk_enable = ($urandom_range(0, 99) < 85);
            trap_done = ($urandom_range(0, 99) < 92);
            csr_ready = ($urandom_range(0, 99) < 92);
            standby_mode = ($urandom_range(0, 99) < 6);
            pth_done_flush = ($urandom_range(0, 99) < 4);
            branch_prediction_miss = ($urandom_range(0, 99) < 4);
            EX_jump = ($urandom_range(0, 99) < 3);
            ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
            ID_rs1_used = 1'($urandom); ID_rs2_used = 1'($urandom);
            EX_rs1 = 5'($urandom_range(0, 3)); EX_rs2 = 5'($urandom_range(0, 3));
            EX_rd = 5'($urandom_range(0, 3)); EX_is_load = ($urandom_range(0, 99) < 30);
            src_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            src_we = 2'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised successor to the single-issue pipeline hazard unit used in the RV32I 5-stage core.
- Produces per-operand forwarding selects from N external forwarding sources plus an internal retire-history chain of configurable depth.
- Enforces a multi-cycle load-use interlock through a counter FSM.
- Merges trap, CSR-ready, standby, redirect and pipeline-flush requests into per-boundary stall and flush vectors.
- Sits in the core top beside the register file and the trap controller; drives all pipeline-register enables and clears.

Parameters:
- FWD_SRCS, 2, number of external forwarding stages; index 0 is youngest (MEM), then WB.
- RET_DEPTH, 1, internal retire-history entries appended after the external sources; 0 allowed.
- LOAD_USE_CYCLES, 1, total stall cycles inserted per load-use hazard; range 1..15.
- NB, 4, number of pipeline boundaries; bit 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB.
- SELW, $clog2(FWD_SRCS+RET_DEPTH+1), width of the forwarding-select fields.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global clock qualifier; all state advances only when high
- trap_done  in  1  trap controller idle
- csr_ready  in  1  CSR file ready
- standby_mode  in  1  front-end hold request
- pth_done_flush  in  1  full-pipeline flush request
- branch_prediction_miss  in  1  EX redirect
- EX_jump  in  1  EX jump redirect
- ID_rs1, ID_rs2  in  5 each  decode source registers
- ID_rs1_used, ID_rs2_used  in  1 each  source actually read
- EX_rs1, EX_rs2, EX_rd  in  5 each  execute-stage registers
- EX_is_load  in  1  EX holds a load
- src_rd  in  5*FWD_SRCS  packed destination registers of the external sources
- src_we  in  FWD_SRCS  write enables of the external sources
- fwd_sel_rs1, fwd_sel_rs2  out  SELW each  0 = register file; k = source k-1
- stall  out  NB  hold the boundary register
- flush  out  NB  clear the boundary register to a bubble
- load_stall_active  out  1  interlock FSM is not in RUN

Behaviour:
- Reset (reset_n low, asynchronous): FSM = RUN, counter = 0, all retire entries have we = 0 and rd = 0. All outputs are 0 while in reset.
- Retire chain:
  - On clk_enable with stall[NB-1] = 0, entry 0 captures the oldest external source (rd, we) and entry i captures entry i-1.
  - When stall[NB-1] = 1, the chain holds.
  - The datapath keeps a matching data chain.
- Forwarding (combinational):
  - Sources are ordered external 0..FWD_SRCS-1, then retire 0..RET_DEPTH-1.
  - fwd_sel picks the lowest-index source with we = 1, rd != 0 and rd == EX_rsX.
  - If no source matches, fwd_sel = 0.
- Load-use detect: EX_is_load && EX_rd != 0 && ((ID_rs1_used && EX_rd == ID_rs1) || (ID_rs2_used && EX_rd == ID_rs2)).
- FSM states: RUN, LU_STALL.
  - RUN: on detect, assert stall[1:0] = 11 and flush[2] = 1 in the same cycle. If LOAD_USE_CYCLES > 1, go to LU_STALL with count = LOAD_USE_CYCLES-1.
  - LU_STALL: assert stall[1:0] and flush[2] every cycle. Decrement count on clk_enable; at count = 1, return to RUN.
  - Only clk_enable advances the FSM.
  - Hazard detect is ignored while in LU_STALL.
- Redirect: trap_done && (branch_prediction_miss || EX_jump) gives flush[1:0] = 11. This overrides stall on those bits, and the FSM aborts to RUN.
- pth_done_flush: flush = all ones and the FSM is forced to RUN next edge. It takes priority over the load-use flush pattern.
- Hold priority (applied last, to stall only):
  - standby_mode: stall[1:0] = 11 and stall[NB-1:2] = 0.
  - Otherwise, if !trap_done || !csr_ready: stall = all ones.
  - While the global hold is active, the FSM and its counter freeze.
- Simultaneous detect and pth_done_flush: the flush wins and no stall is entered.
- Simultaneous detect and redirect: the redirect wins.

Optional Feature:
- Macro: HAZARD_CSR_FWD_EN.
- When defined, add ports:
  - src_csr_we in FWD_SRCS
  - src_csr_addr in 12*FWD_SRCS
  - EX_csr_addr in 12
  - csr_fwd_sel out SELW
- csr_fwd_sel uses the same youngest-first priority as GPR forwarding, over the external sources only.
- When undefined, these ports are absent and CSR reads always use the CSR file.

Test Plan:
- src_rd = {WB: x5, MEM: x5}, both we = 1, EX_rs1 = 5 -> fwd_sel_rs1 = 1 (MEM wins); with MEM we = 0 -> fwd_sel_rs1 = 2.
- RET_DEPTH = 1: WB writes x7, next cycle no source matches, EX_rs2 = 7 -> fwd_sel_rs2 = FWD_SRCS+1; EX_rs2 = 0 -> fwd_sel_rs2 = 0.
- LOAD_USE_CYCLES = 3, EX load rd = x3, ID_rs1 = 3 used -> stall[1:0] = 11 and flush[2] = 1 for exactly 3 cycles, then release. Same case with ID_rs1_used = 0 -> no stall.
- Load-use interlock active in its 2nd cycle, pth_done_flush pulse -> flush = 1111, FSM back in RUN next cycle, load_stall_active = 0.
- csr_ready = 0 for 4 cycles during LU_STALL -> stall = 1111 and the counter frozen; the stall completes its remaining cycles after csr_ready rises.
- reset_n low mid-LU_STALL -> outputs 0 immediately; after release, no residual stall.
